msx_mouse_port: RTL and testbench
=================================

Name: msx_mouse_port

Overview:
- Converts MiSTer hps_io `ps2_mouse` packets into the MSX mouse protocol on a general-purpose joystick port.
- Upstream of the emsx joystick inputs: its `data` drives pJoyA/pJoyB when mouse mode is active; the port's pStr output drives `strobe`.
- Accumulates PS/2 motion between MSX reads, then serves it as four 4-bit nibbles clocked by strobe edges.

Parameters:
- CLK_HZ, 21477270: clk_sys frequency in Hz.
- TIMEOUT_US, 1500: strobe-idle time after which the nibble phase returns to 0.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_mouse  in  25  [24] packet toggle, [23:16] dy, [15:8] dx, [7:0] PS/2 status byte (b0 left, b1 right, b4 X sign, b5 Y sign).
- strobe  in  1  MSX port pin 8, asynchronous to clk_sys.
- data  out  6  [3:0] nibble; [4] button1 (active-low, PS/2 left); [5] button2 (active-low, PS/2 right).
- active  out  1  pulses for 1 cycle on each accepted ps2_mouse packet.

Behaviour:
- Reset values: data=6'b111111, active=0, phase=0, accX=accY=0, latX=latY=0, timer=0, buttons released.
- strobe sync: 2-flop synchronizer, then edge detect. Any transition (rise or fall) is one strobe event; latency from pin to event is 3 clk_sys.
- Packet intake: a change of ps2_mouse[24] versus its registered copy accepts one packet. active=1 in the following cycle.
  - Deltas are 9-bit signed: {status[4],dx} and {status[5],dy}.
  - Buttons register from status[1:0] in the same cycle.
- Accumulators accX/accY are 10-bit signed.
  - accX += dx; accY -= dy, because PS/2 up is positive and MSX down is positive.
  - After each add, saturate to [-128,+127].
- Phase counter, 2 bits, advances once per strobe event, wrapping 3 -> 0. The nibble shown is selected by the phase:
  - phase 0: latX[7:4]
  - phase 1: latX[3:0]
  - phase 2: latY[7:4]
  - phase 3: latY[3:0]
- Latch: on a strobe event while phase==3, or on the first event after a timeout:
  - latX = -accX[7:0] (two's complement, 8-bit; -(-128) wraps to 0x80) and latY = -accY[7:0].
  - accX/accY are then reduced by the latched amount (cleared to 0), and phase goes to 0.
- Simultaneous packet and latch in one cycle: the latch takes the pre-add accumulator value; the accumulator becomes that cycle's packet delta (saturated). No motion is lost.
- Timeout timer:
  - Counts clk_sys cycles since the last strobe event and saturates at TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US.
  - On reaching TIMEOUT_CYC, phase is forced to 3, so the next event latches and shows phase 0.
- data[3:0] is registered and updates one cycle after the phase/latch change. data[5:4] = ~buttons, registered.
- reset_n asserted mid-read: all state returns to reset values immediately. The first strobe event after release latches zero deltas.

Optional Feature:
- Macro: MSX_MOUSE_ACCEL_EN.
- Defined: before accumulation, any packet delta with |d| > 8 is doubled (computed in 10 bits), then the normal saturation applies.
- Undefined: deltas are accumulated unmodified. No accel logic is synthesized.

Decomposition:
- Package msx_mouse_pkg holds:
  - typedef phase_t (2-bit: P_XH, P_XL, P_YH, P_YL);
  - typedef acc_t (logic signed [9:0]);
  - constants ACC_MAX=127, ACC_MIN=-128, ACCEL_THRESH=8;
  - function sat8(acc_t).
- One sub-module, msx_strobe_sync: 2-flop synchronizer plus any-edge pulse output, with async active-low reset.

Test Plan:
- Reset, then one packet dx=+5 (status b4=0), dy=0, followed by 4 strobe toggles 10 us apart -> nibbles 0xF, 0xB, 0x0, 0x0 (latX=0xFB, latY=0x00); `active` pulses once.
- Three packets, each dy=+100 (up) -> accY saturates at -128, latY=0x80; read nibbles on the 3rd and 4th events = 0x8, 0x0.
- Two toggles, then no strobe for 2 ms, then a toggle -> phase resets, and the data nibble is latX[7:4] of freshly latched data, not latY[7:4].
- Packet dx=+3 arrives in the same cycle as the latching event when accX=+2 -> latX=0xFE; the next full read yields latX=0xFD.
- status[1:0]=2'b11 -> data[5:4]=2'b00 within 2 cycles; release -> 2'b11. Independent of phase.
- With MSX_MOUSE_ACCEL_EN defined, dx=+10 -> accX=+20, latX=0xEC. Without the macro -> latX=0xF6.

Source files
------------

// File: rtl/msx_mouse_port_pkg.sv
// msx_mouse_pkg: shared types, limits and saturation helper for the MSX mouse port.
// Provides phase_t (nibble phase), acc_t (10-bit signed motion accumulator),
// ACC_MAX/ACC_MIN saturation limits, ACCEL_THRESH and sat8().
package msx_mouse_pkg;

    typedef enum logic [1:0] {P_XH, P_XL, P_YH, P_YL} phase_t;

    typedef logic signed [9:0] acc_t;

    localparam acc_t ACC_MAX      = 10'sd127;
    localparam acc_t ACC_MIN      = -10'sd128;
    localparam acc_t ACCEL_THRESH = 10'sd8;

    function automatic acc_t sat8(acc_t a);
        return a > ACC_MAX ? ACC_MAX : a < ACC_MIN ? ACC_MIN : a;
    endfunction

endpackage

// File: rtl/msx_mouse_port_if.sv
// msx_mouse_port_if: bus between the HPS mouse source / MSX port and msx_mouse_port.
// ps2_mouse[24:0] packet (toggle, dy, dx, status), strobe (MSX pin 8),
// data[5:0] nibble plus active-low buttons, active (packet accepted pulse).
interface msx_mouse_port_if;

    logic [24:0] ps2_mouse;
    logic        strobe;
    logic [5:0]  data;
    logic        active;

    modport master (output ps2_mouse, strobe, input data, active);
    modport slave  (input ps2_mouse, strobe, output data, active);

endinterface

// File: rtl/msx_mouse_port_strobe_sync.sv
// msx_strobe_sync: brings the asynchronous MSX strobe into clk_sys and pulses on either edge.
// Ports: clk_sys, reset_n (async active-low), strobe (async pin), evt (1-cycle pulse,
// registered, three clk_sys after the pin changes).
module msx_strobe_sync (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic strobe,
    output logic evt
);

    logic [2:0] s;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s   <= '0;
            evt <= 1'b0;
        end else begin
            s   <= {s[1:0], strobe};
            evt <= s[1] ^ s[2];
        end
    end

endmodule

// File: rtl/msx_mouse_port.sv
// msx_mouse_port: turns hps_io ps2_mouse packets into the MSX nibble-serial mouse protocol.
// Ports: clk_sys, reset_n (async active-low), bus (msx_mouse_port_if.slave:
// ps2_mouse/strobe in, data/active out).
// Parameters: CLK_HZ (clk_sys in Hz), TIMEOUT_US (strobe-idle time before the read restarts).
// Optional: define MSX_MOUSE_ACCEL_EN to double packet deltas whose magnitude exceeds 8.
module msx_mouse_port
    import msx_mouse_pkg::*;
#(
    parameter int CLK_HZ     = 21477270,
    parameter int TIMEOUT_US = 1500
) (
    input logic               clk_sys,
    input logic               reset_n,
    msx_mouse_port_if.slave   bus
);

    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);

`ifdef MSX_MOUSE_ACCEL_EN
    // Doubled deltas are clamped to the 9-bit input range; with the accumulator
    // already inside [-128,127] this cannot change the saturated result but
    // keeps the sum inside 10 bits.
    function automatic acc_t shape(acc_t d);
        acc_t m;
        m = (d > ACCEL_THRESH || d < -ACCEL_THRESH) ? d <<< 1 : d;
        return m > acc_t'(255) ? acc_t'(255) : m < acc_t'(-256) ? acc_t'(-256) : m;
    endfunction
`else
    function automatic acc_t shape(acc_t d);
        return d;
    endfunction
`endif

    logic          evt, pkt, latch, tout, tog_q;
    logic [1:0]    btn;
    logic [7:0]    lat_x, lat_y;
    logic [3:0]    nib;
    logic [TW-1:0] timer;
    phase_t        phase;
    acc_t          acc_x, acc_y, dx_d, dy_d, base_x, base_y, nx, ny;

    msx_strobe_sync u_sync (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .strobe  (bus.strobe),
        .evt     (evt)
    );

    assign pkt    = bus.ps2_mouse[24] ^ tog_q;
    assign tout   = timer == TW'(TIMEOUT_CYC);
    assign latch  = evt && (phase == P_YL || tout);
    assign dx_d   = shape(acc_t'($signed({bus.ps2_mouse[4], bus.ps2_mouse[15:8]})));
    assign dy_d   = shape(acc_t'($signed({bus.ps2_mouse[5], bus.ps2_mouse[23:16]})));
    // A latch hands the whole accumulator to the reader, so a packet arriving in
    // the same cycle starts from zero and nothing is dropped.
    assign base_x = latch ? '0 : acc_x;
    assign base_y = latch ? '0 : acc_y;
    // PS/2 up is positive, MSX down is positive: Y is subtracted.
    assign nx     = pkt ? sat8(base_x + dx_d) : base_x;
    assign ny     = pkt ? sat8(base_y - dy_d) : base_y;
    assign nib    = phase == P_XH ? lat_x[7:4] :
                    phase == P_XL ? lat_x[3:0] :
                    phase == P_YH ? lat_y[7:4] : lat_y[3:0];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q      <= 1'b0;
            acc_x      <= '0;
            acc_y      <= '0;
            lat_x      <= '0;
            lat_y      <= '0;
            phase      <= P_XH;
            timer      <= '0;
            btn        <= '0;
            bus.data   <= 6'b111111;
            bus.active <= 1'b0;
        end else begin
            tog_q      <= bus.ps2_mouse[24];
            bus.active <= pkt;
            acc_x      <= nx;
            acc_y      <= ny;
            if (pkt)
                btn <= bus.ps2_mouse[1:0];
            if (latch) begin
                lat_x <= -acc_x[7:0];
                lat_y <= -acc_y[7:0];
            end
            timer    <= evt ? '0 : tout ? timer : timer + 1'b1;
            // Timeout parks the phase at P_YL so the next strobe latches fresh data.
            phase    <= latch ? P_XH : evt ? phase_t'(phase + 2'd1) : tout ? P_YL : phase;
            bus.data <= {~btn, nib};
        end
    end

endmodule

// File: tb/tb_msx_mouse_port.sv
// tb_msx_mouse_port: directed self-checking bench for msx_mouse_port.
module tb_msx_mouse_port;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    msx_mouse_port_if bus ();

    msx_mouse_port #(.TIMEOUT_US(200)) dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #23 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy);
        @(negedge clk);
        bus.ps2_mouse = {~bus.ps2_mouse[24], dy, dx, st};
        @(posedge clk);
        #1;
    endtask

    task automatic tog(input string tag, input logic [3:0] exp);
        @(negedge clk);
        bus.strobe = ~bus.strobe;
        repeat (6) @(posedge clk);
        #1;
        chk(tag, {2'b00, bus.data[3:0]}, {2'b00, exp});
        repeat (200) @(posedge clk);
    endtask

    initial begin
        bus.ps2_mouse = '0;
        bus.strobe    = 1'b0;
        #100;
        chk("reset_data", bus.data, 6'h3F);
        chk("reset_active", {5'b0, bus.active}, 6'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5000) @(posedge clk);

        // one packet dx=+5
        send(8'h00, 8'd5, 8'd0);
        chk("active_pulse", {5'b0, bus.active}, 6'h1);
        @(posedge clk);
        #1;
        chk("active_clear", {5'b0, bus.active}, 6'h0);
        tog("t1_xh", 4'hF);
        tog("t1_xl", 4'hB);
        tog("t1_yh", 4'h0);
        tog("t1_yl", 4'h0);

        // Y saturation
        repeat (3) send(8'h00, 8'd0, 8'd100);
        tog("t2_xh", 4'h0);
        tog("t2_xl", 4'h0);
        tog("t2_yh", 4'h8);
        tog("t2_yl", 4'h0);

        // timeout restarts the read
        send(8'h00, 8'd32, 8'd0);
        tog("t3_xh", 4'hE);
        tog("t3_xl", 4'h0);
        send(8'h00, 8'd16, 8'h30);
        repeat (5000) @(posedge clk);
        tog("t3_timeout_xh", 4'hF);

        // packet coincident with latch
        send(8'h00, 8'd2, 8'd0);
        tog("t4_xl", 4'h0);
        tog("t4_yh", 4'h3);
        tog("t4_yl", 4'h0);
        @(negedge clk);
        bus.strobe = ~bus.strobe;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.ps2_mouse = {~bus.ps2_mouse[24], 8'd0, 8'd3, 8'h00};
        repeat (2) @(posedge clk);
        #1;
        chk("t4_coinc_xh", {2'b00, bus.data[3:0]}, 6'h0F);
        repeat (200) @(posedge clk);
        tog("t4_coinc_xl", 4'hE);
        tog("t4_yh2", 4'h0);
        tog("t4_yl2", 4'h0);
        tog("t4_next_xh", 4'hF);
        tog("t4_next_xl", 4'hD);

        // buttons
        send(8'h03, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        chk("btn_press", bus.data, 6'h0D);
        send(8'h00, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        chk("btn_release", bus.data, 6'h3D);

        // acceleration option
        tog("t6_yh", 4'h0);
        tog("t6_yl", 4'h0);
        send(8'h00, 8'd10, 8'd0);
`ifdef MSX_MOUSE_ACCEL_EN
        tog("t6_xh", 4'hE);
        tog("t6_xl", 4'hC);
`else
        tog("t6_xh", 4'hF);
        tog("t6_xl", 4'h6);
`endif

        // reset mid-read
        send(8'h01, 8'd7, 8'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_data", bus.data, 6'h3F);
        chk("mid_reset_active", {5'b0, bus.active}, 6'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5000) @(posedge clk);
        @(negedge clk);
        bus.strobe = ~bus.strobe;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_latch", bus.data, 6'h30);
        repeat (200) @(posedge clk);
        tog("post_reset_xl", 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
